// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and constants for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    WRITE = 1'b1
  } state_e;

  localparam int DATA_W_DEFAULT = 4;
  localparam int STALL_W        = 8;

endpackage

// File: rtl/fifo_arb_drain_timer.sv
// rtl/fifo_arb_drain_timer.sv - paces FIFO reads: one read strobe every DRAIN_DIV cycles while draining
module fifo_arb_drain_timer #(
  parameter int DRAIN_DIV = 100_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic drain_en_i,
  input  logic empty_i,
  output logic r_o
);

  localparam int              CNT_W = $clog2(DRAIN_DIV);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DRAIN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             r_q, r_d;

  // Any pause (empty or disabled) restarts the interval from zero.
  always_comb begin
    cnt_d = '0;
    r_d   = 1'b0;
    if (drain_en_i && !empty_i) begin
      if (cnt_q == TERM) begin
        r_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      r_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      r_q   <= r_d;
    end
  end

  assign r_o = r_q;

endmodule

// File: rtl/fifo_arb.sv
// rtl/fifo_arb.sv - round-robin sharing of the FIFO write port plus paced drain reads
// Optional stall counter built when FIFO_ARB_STATS_EN is defined.
module fifo_arb
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int DRAIN_DIV = 100_000_000
) (
  input  logic               fifo_arb_port_clk,
  input  logic               fifo_arb_port_rst,
  input  logic               fifo_arb_port_req0,
  input  logic [DATA_W-1:0]  fifo_arb_port_data0,
  input  logic               fifo_arb_port_req1,
  input  logic [DATA_W-1:0]  fifo_arb_port_data1,
  output logic               fifo_arb_port_gnt0,
  output logic               fifo_arb_port_gnt1,
  input  logic               fifo_arb_port_full,
  input  logic               fifo_arb_port_empty,
  output logic               fifo_arb_port_w,
  output logic [DATA_W-1:0]  fifo_arb_port_wdata,
  input  logic               fifo_arb_port_drain_en,
  output logic               fifo_arb_port_r,
  output logic [STALL_W-1:0] fifo_arb_port_stall
);

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              pick;

  always_comb begin
    state_d            = state_q;
    ptr_d              = ptr_q;
    sel_d              = sel_q;
    wdata_d            = wdata_q;
    pick               = 1'b0;
    fifo_arb_port_w    = 1'b0;
    fifo_arb_port_gnt0 = 1'b0;
    fifo_arb_port_gnt1 = 1'b0;
    case (state_q)
      ARB: begin
        if (!fifo_arb_port_full && (fifo_arb_port_req0 || fifo_arb_port_req1)) begin
          pick    = (fifo_arb_port_req0 && fifo_arb_port_req1) ? ptr_q : fifo_arb_port_req1;
          sel_d   = pick;
          wdata_d = pick ? fifo_arb_port_data1 : fifo_arb_port_data0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // A reset landing on the WRITE cycle suppresses the strobe and grant.
        fifo_arb_port_w    = ~fifo_arb_port_rst;
        fifo_arb_port_gnt0 = ~fifo_arb_port_rst & ~sel_q;
        fifo_arb_port_gnt1 = ~fifo_arb_port_rst & sel_q;
        ptr_d              = ~sel_q;
        state_d            = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge fifo_arb_port_clk) begin
    if (fifo_arb_port_rst) begin
      state_q <= ARB;
      ptr_q   <= 1'b0;
      sel_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
    end
  end

  assign fifo_arb_port_wdata = wdata_q;

  fifo_arb_drain_timer #(
    .DRAIN_DIV(DRAIN_DIV)
  ) u_drain_timer (
    .clk_i      (fifo_arb_port_clk),
    .rst_i      (fifo_arb_port_rst),
    .drain_en_i (fifo_arb_port_drain_en),
    .empty_i    (fifo_arb_port_empty),
    .r_o        (fifo_arb_port_r)
  );

`ifdef FIFO_ARB_STATS_EN
  logic [STALL_W-1:0] stall_q;

  always_ff @(posedge fifo_arb_port_clk) begin
    if (fifo_arb_port_rst) begin
      stall_q <= '0;
    end else if (state_q == ARB && (fifo_arb_port_req0 || fifo_arb_port_req1) &&
                 fifo_arb_port_full && stall_q != '1) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign fifo_arb_port_stall = stall_q;
`else
  assign fifo_arb_port_stall = '0;
`endif

endmodule
